generic_2clk_fifo_wr_arb: RTL
=============================

// Module: generic_2clk_fifo_wr_arb
// PURPOSE
//  Write-side arbiter/sequencer for one generic 2-clock FIFO envelope (1r1w compiled RAM).
//  Shares the single FIFO write port among NUM_REQ requesters using packet-locked round-robin.
//  Uses wr_entry_used to throttle writes, so the FIFO is never written while full.
//  Runs entirely in the FIFO write clock domain.
// PARAMETERS
//  NUM_REQ        4    number of requesters (2..8)
//  DAT_WIDTH      36   FIFO data width
//  PTR_WIDTH      4    FIFO address width; entry_used is PTR_WIDTH+1 bits
//  NUM_OF_ENTRIES 16   FIFO depth
//  WDOG_CYC       64   idle-beat timeout in cycles (used only with the macro)
// PORTS
//  clk                 in   1                   write clock (same clock as FIFO wr_clk)
//  reset               in   1                   synchronous, active-high
//  req_valid           in   NUM_REQ             per-requester beat valid
//  req_last            in   NUM_REQ             last beat of the requester's packet
//  req_data            in   NUM_REQ*DAT_WIDTH   requester i occupies bits [i*DAT_WIDTH +: DAT_WIDTH]
//  req_ready           out  NUM_REQ             beat accepted this cycle (combinational)
//  fifo_wr_op          out  1                   to FIFO wr_op, registered
//  fifo_wr_data        out  DAT_WIDTH           to FIFO wr_data, registered
//  fifo_wr_mask        out  DAT_WIDTH           to FIFO wr_mask; constant all-ones
//  fifo_wr_full        in   1                   from FIFO wr_full
//  fifo_wr_entry_used  in   PTR_WIDTH+1         from FIFO wr_entry_used
//  fifo_wr_full_err    in   1                   from FIFO wr_full_err
//  grant_id            out  $clog2(NUM_REQ)     currently or last granted requester
//  busy                out  1                   1 while in BURST
//  ovf_err             out  1                   sticky; set when fifo_wr_full_err is seen
//  wdog_err            out  1                   1-cycle pulse on watchdog abort (0 without the macro)
// BEHAVIOUR
//  Reset values: fifo_wr_op=0, fifo_wr_data=0, grant_id=0, busy=0, ovf_err=0, wdog_err=0.
//  Reset also sets rr_ptr=0 and state=IDLE.
//  Space check:
//   - occ = fifo_wr_entry_used + fifo_wr_op. The in-flight registered write is not yet
//     counted by the FIFO, so it is added here.
//   - can_wr = !fifo_wr_full && (occ < NUM_OF_ENTRIES). Compute occ at PTR_WIDTH+2 bits; it must not wrap.
//  Arbitration:
//   - IDLE: sel = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - The grant applies in the same cycle. grant_id <= sel on the next edge.
//  req_ready[i] = can_wr && (i == cur), where cur = sel in IDLE and cur = grant_id in BURST.
//  All other ready bits are 0.
//  Accept (req_valid[cur] && req_ready[cur]): on the next edge fifo_wr_op=1 and fifo_wr_data=req_data[cur].
//  Otherwise fifo_wr_op=0 and fifo_wr_data holds its value. Latency: requester beat to FIFO write = 1 cycle.
//  FSM:
//   - IDLE->BURST: a beat is accepted without req_last.
//   - IDLE->IDLE: a single-beat packet (accepted with req_last); rr_ptr <= sel+1.
//   - BURST->IDLE: the accepted beat has req_last; rr_ptr <= grant_id+1 (mod NUM_REQ).
//   - BURST holds: the grant stays locked through bubbles and through can_wr=0.
//  In IDLE with no valid requester, or with can_wr=0, the FSM stays in IDLE and rr_ptr is unchanged.
//  A requester blocked by can_wr=0 in IDLE is not yet granted; arbitration is re-evaluated every cycle.
//  Boundaries:
//   - occ==NUM_OF_ENTRIES-1 with fifo_wr_op=0: exactly one beat is accepted, then ready drops.
//   - rr_ptr wraps from NUM_REQ-1 to 0.
//   - Simultaneous requests are ordered strictly by the rotating priority.
//   - Reset mid-burst aborts the packet. The partial packet already in the FIFO is not recalled.
//   - fifo_wr_full_err sets ovf_err, which clears only on reset. The design must never cause this.
// CONFIGURATION
//  WR_ARB_WDOG_EN defined:
//   - In BURST, a counter counts cycles with req_valid[grant_id]=0. It clears on any valid beat.
//   - When the count reaches WDOG_CYC: wdog_err pulses, state returns to IDLE, rr_ptr <= grant_id+1.
//   - The FIFO is not written on the abort cycle.
//  WR_ARB_WDOG_EN undefined: no counter; the grant is held indefinitely; wdog_err is tied to 0.
// TESTING
//  T1 reset: assert reset 2 cycles with all req_valid=1 -> all outputs 0, no fifo_wr_op.
//  T2 RR fairness: req 0..3 each send 2-beat packets, all valid continuously
//     -> FIFO order 0,0,1,1,2,2,3,3,0,0; each packet contiguous.
//  T3 full throttle: hold entry_used=15 (depth 16) and inject one beat
//     -> exactly 1 fifo_wr_op; then ready=0 while occ=16.
//  T4 burst lock: req1 in BURST with 3 bubble cycles while req2 is valid
//     -> req2 stays blocked until req1's last beat, then is granted next.
//  T5 error flag: pulse fifo_wr_full_err 1 cycle -> ovf_err=1 stays high until reset.
//  T6 WR_ARB_WDOG_EN, WDOG_CYC=8: req0 stalls 8 cycles mid-packet
//     -> wdog_err pulse, busy=0, waiting req1 granted the following cycle.

Source files
------------

// File: rtl/generic_2clk_fifo_wr_arb.sv
// Write-side arbiter for a 2-clock FIFO: packet-locked round-robin over NUM_REQ requesters.
// Define WR_ARB_WDOG_EN to enable the idle-beat watchdog that aborts a stalled burst.
module generic_2clk_fifo_wr_arb #(
   parameter int NUM_REQ        = 4,
   parameter int DAT_WIDTH      = 36,
   parameter int PTR_WIDTH      = 4,
   parameter int NUM_OF_ENTRIES = 16,
   parameter int WDOG_CYC       = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_last,
   input  logic [NUM_REQ*DAT_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         fifo_wr_op,
   output logic [DAT_WIDTH-1:0]         fifo_wr_data,
   output logic [DAT_WIDTH-1:0]         fifo_wr_mask,
   input  logic                         fifo_wr_full,
   input  logic [PTR_WIDTH:0]           fifo_wr_entry_used,
   input  logic                         fifo_wr_full_err,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         ovf_err,
   output logic                         wdog_err
);

   localparam int GW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYC < 1) begin : g_cfg_err
      $error("generic_2clk_fifo_wr_arb: bad parameter set");
   end

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state;
   logic [GW-1:0]        rr_ptr;
   logic [GW-1:0]        sel;
   logic [GW-1:0]        cur;
   logic [PTR_WIDTH+1:0] occ;
   logic                 can_wr;
   logic                 cur_valid;
   logic                 cur_last;
   logic                 accept;
   logic                 abort;
   logic [DAT_WIDTH-1:0] cur_data;

   function automatic logic [GW-1:0] ptr_inc(input logic [GW-1:0] p);
      return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   // The registered write is not yet visible in entry_used, so count it here.
   assign occ    = {1'b0, fifo_wr_entry_used} + {{(PTR_WIDTH+1){1'b0}}, fifo_wr_op};
   assign can_wr = !fifo_wr_full && (occ < (PTR_WIDTH+2)'(NUM_OF_ENTRIES));

   always_comb begin
      int  idx;
      logic found;
      sel   = rr_ptr;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            sel   = GW'(idx);
            found = 1'b1;
         end
      end
   end

   assign cur       = (state == BURST) ? grant_id : sel;
   assign cur_valid = req_valid[cur];
   assign cur_last  = req_last[cur];
   assign cur_data  = req_data[int'(cur)*DAT_WIDTH +: DAT_WIDTH];
   assign accept    = cur_valid && can_wr;

   always_comb begin
      req_ready      = '0;
      req_ready[cur] = can_wr;
   end

   assign fifo_wr_mask = '1;

`ifdef WR_ARB_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0] wdog_cnt;

   assign abort = (state == BURST) && !cur_valid &&
                  (wdog_cnt == WW'(WDOG_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset || state != BURST || cur_valid || abort)
         wdog_cnt <= '0;
      else
         wdog_cnt <= wdog_cnt + 1'b1;
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_id     <= '0;
         busy         <= 1'b0;
         fifo_wr_op   <= 1'b0;
         fifo_wr_data <= '0;
         ovf_err      <= 1'b0;
         wdog_err     <= 1'b0;
      end else begin
         fifo_wr_op <= accept;
         if (accept) fifo_wr_data <= cur_data;
         if (fifo_wr_full_err) ovf_err <= 1'b1;
         wdog_err <= abort;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  grant_id <= sel;
                  if (cur_last) begin
                     rr_ptr <= ptr_inc(sel);
                  end else begin
                     state <= BURST;
                     busy  <= 1'b1;
                  end
               end
            end
            BURST: begin
               if (abort || (accept && cur_last)) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  rr_ptr <= ptr_inc(grant_id);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
